// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with fill count, almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Standard mode: 1-cycle read latency. FWFT mode: head shown combinationally. Writes into a full FIFO are rejected unless a read is accepted in the same cycle.
module sync_fifo_flags #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    parameter int FWFT     = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       w_en,
    input  logic [WIDTH-1:0]           data_in,
    input  logic                       r_en,
    output logic [WIDTH-1:0]           data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_C     = CW'(AE_LEVEL);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_acc, wr_acc;
    logic             is_full, is_empty;

    assign is_full  = (count_q == FULL_C);
    assign is_empty = (count_q == '0);
    assign rd_acc   = r_en && !is_empty;
    // A full FIFO still takes a write when the same edge frees a slot.
    assign wr_acc   = w_en && (!is_full || rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        ovf_d    = ovf_q | (w_en && !wr_acc);
        unf_d    = unf_q | (r_en && !rd_acc);
        if (wr_acc) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
            dout_d   = mem[rd_ptr_q];
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    // Storage carries no reset; stale words are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT != 0) begin : g_fwft
            // When drained, dout_q holds the last popped word (or 0 after reset).
            assign data_out = is_empty ? dout_q : mem[rd_ptr_q];
        end else begin : g_std
            assign data_out = dout_q;
        end
    endgenerate

    assign full         = is_full;
    assign empty        = is_empty;
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench: standard-mode FIFO (DEPTH=8) and FWFT FIFO (DEPTH=5, odd depth to exercise pointer wrap).
module tb_sync_fifo_flags;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Instance A: DEPTH=8, AF=6, AE=2, standard read mode
    logic       a_rst = 1'b0, a_w_en = 1'b0, a_r_en = 1'b0;
    logic [7:0] a_din = '0, a_dout;
    logic       a_full, a_empty, a_af, a_ae, a_ovf, a_unf;
    logic [3:0] a_cnt;

    // Instance B: DEPTH=5, AF=3, AE=2, FWFT
    logic       b_rst = 1'b0, b_w_en = 1'b0, b_r_en = 1'b0;
    logic [7:0] b_din = '0, b_dout;
    logic       b_full, b_empty, b_af, b_ae, b_ovf, b_unf;
    logic [2:0] b_cnt;

    sync_fifo_flags #(.DEPTH(8), .WIDTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)) u_a (
        .clk(clk), .rst(a_rst), .w_en(a_w_en), .data_in(a_din), .r_en(a_r_en),
        .data_out(a_dout), .full(a_full), .empty(a_empty), .almost_full(a_af),
        .almost_empty(a_ae), .count(a_cnt), .overflow(a_ovf), .underflow(a_unf)
    );

    sync_fifo_flags #(.DEPTH(5), .WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(2), .FWFT(1)) u_b (
        .clk(clk), .rst(b_rst), .w_en(b_w_en), .data_in(b_din), .r_en(b_r_en),
        .data_out(b_dout), .full(b_full), .empty(b_empty), .almost_full(b_af),
        .almost_empty(b_ae), .count(b_cnt), .overflow(b_ovf), .underflow(b_unf)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge, then settle 1 time unit before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---------------- Instance A: reset state ----------------
        #2;
        chk("a_rst_cnt",   16'(a_cnt),   16'd0);
        chk("a_rst_empty", 16'(a_empty), 16'd1);
        chk("a_rst_full",  16'(a_full),  16'd0);
        chk("a_rst_ae",    16'(a_ae),    16'd1);
        chk("a_rst_af",    16'(a_af),    16'd0);
        chk("a_rst_dout",  16'(a_dout),  16'd0);
        chk("a_rst_ovf",   16'(a_ovf),   16'd0);
        chk("a_rst_unf",   16'(a_unf),   16'd0);
        a_rst = 1'b1;

        // Fill 0x01..0x08
        for (int i = 1; i <= 8; i++) begin
            a_w_en = 1'b1; a_din = 8'(i);
            step();
            chk("a_fill_cnt",  16'(a_cnt),  16'(i));
            chk("a_fill_ae",   16'(a_ae),   16'(i <= 2));
            chk("a_fill_af",   16'(a_af),   16'(i >= 6));
            chk("a_fill_full", 16'(a_full), 16'(i == 8));
            chk("a_fill_ovf",  16'(a_ovf),  16'd0);
        end

        // Overflow from full
        a_din = 8'hAA;
        step();
        a_w_en = 1'b0;
        chk("a_ovf_set", 16'(a_ovf), 16'd1);
        chk("a_ovf_cnt", 16'(a_cnt), 16'd8);
        step();
        chk("a_ovf_sticky", 16'(a_ovf), 16'd1);

        // Drain: one-cycle latency
        a_r_en = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            step();
            chk("a_drain_dout", 16'(a_dout), 16'(i));
            chk("a_drain_cnt",  16'(a_cnt),  16'(8 - i));
        end
        a_r_en = 1'b0;
        chk("a_drain_empty", 16'(a_empty), 16'd1);
        chk("a_drain_ae",    16'(a_ae),    16'd1);

        // Simultaneous read+write on empty
        a_r_en = 1'b1; a_w_en = 1'b1; a_din = 8'h55;
        step();
        a_w_en = 1'b0;
        chk("a_unf_set",  16'(a_unf),  16'd1);
        chk("a_unf_cnt",  16'(a_cnt),  16'd1);
        chk("a_unf_dout", 16'(a_dout), 16'h08);
        step();
        a_r_en = 1'b0;
        chk("a_unf_read", 16'(a_dout), 16'h55);
        chk("a_unf_cnt0", 16'(a_cnt),  16'd0);

        // Fresh reset, fill, then read+write while full
        #2; a_rst = 1'b0; #1;
        chk("a_rst2_unf", 16'(a_unf), 16'd0);
        a_rst = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            a_w_en = 1'b1; a_din = 8'(i);
            step();
        end
        chk("a_full2", 16'(a_full), 16'd1);
        a_r_en = 1'b1; a_din = 8'h99;
        step();
        a_w_en = 1'b0;
        chk("a_rw_cnt",  16'(a_cnt),  16'd8);
        chk("a_rw_ovf",  16'(a_ovf),  16'd0);
        chk("a_rw_dout", 16'(a_dout), 16'h01);
        for (int i = 2; i <= 9; i++) begin
            step();
            chk("a_wrap_dout", 16'(a_dout), (i == 9) ? 16'h99 : 16'(i));
        end
        a_r_en = 1'b0;
        chk("a_wrap_empty", 16'(a_empty), 16'd1);

        // ---------------- Instance B: FWFT ----------------
        chk("b_rst_dout",  16'(b_dout),  16'd0);
        chk("b_rst_empty", 16'(b_empty), 16'd1);
        #2; b_rst = 1'b1;
        b_w_en = 1'b1; b_din = 8'h3C;
        step();
        b_w_en = 1'b0;
        chk("b_fwft_empty", 16'(b_empty), 16'd0);
        chk("b_fwft_dout",  16'(b_dout),  16'h3C);
        b_w_en = 1'b1; b_din = 8'h3D;
        step();
        b_w_en = 1'b0;
        chk("b_fwft_head", 16'(b_dout), 16'h3C);
        b_r_en = 1'b1;
        step();
        chk("b_pop_dout", 16'(b_dout), 16'h3D);
        chk("b_pop_cnt",  16'(b_cnt),  16'd1);
        step();
        chk("b_last_empty", 16'(b_empty), 16'd1);
        chk("b_last_hold",  16'(b_dout),  16'h3D);
        step();
        b_r_en = 1'b0;
        chk("b_unf_set",  16'(b_unf),  16'd1);
        chk("b_unf_hold", 16'(b_dout), 16'h3D);

        // Fill 5, overflow once, then async reset between edges
        for (int i = 0; i < 5; i++) begin
            b_w_en = 1'b1; b_din = 8'hA0 + 8'(i);
            step();
        end
        chk("b_full", 16'(b_full), 16'd1);
        chk("b_af",   16'(b_af),   16'd1);
        chk("b_head", 16'(b_dout), 16'hA0);
        step();
        b_w_en = 1'b0;
        chk("b_ovf_set", 16'(b_ovf), 16'd1);
        #2; b_rst = 1'b0; #1;
        chk("b_arst_cnt",   16'(b_cnt),   16'd0);
        chk("b_arst_empty", 16'(b_empty), 16'd1);
        chk("b_arst_ovf",   16'(b_ovf),   16'd0);
        chk("b_arst_unf",   16'(b_unf),   16'd0);
        chk("b_arst_dout",  16'(b_dout),  16'd0);
        b_rst = 1'b1;

        b_w_en = 1'b1; b_din = 8'h77;
        step();
        b_w_en = 1'b0;
        chk("b_post_dout", 16'(b_dout), 16'h77);
        b_r_en = 1'b1;
        step();
        b_r_en = 1'b0;
        chk("b_post_empty", 16'(b_empty), 16'd1);
        chk("b_post_hold",  16'(b_dout),  16'h77);

        // Pointers start at 1 here, so five writes wrap past entry 4 of a 5-deep FIFO
        for (int i = 1; i <= 5; i++) begin
            b_w_en = 1'b1; b_din = 8'hB0 + 8'(i);
            step();
        end
        b_w_en = 1'b0;
        chk("b_wrap_full", 16'(b_full), 16'd1);
        for (int i = 1; i <= 5; i++) begin
            chk("b_wrap_dout", 16'(b_dout), 16'hB0 + 16'(i));
            b_r_en = 1'b1;
            step();
        end
        b_r_en = 1'b0;
        chk("b_wrap_empty", 16'(b_empty), 16'd1);
        chk("b_wrap_ovf",   16'(b_ovf),   16'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
